// File: rtl/percept_datapath.sv
// Serial-loaded perceptron MAC: bit-serial operand chain, sequential signed shift-add
// multiplier, accumulator and serial result readout. Define PERCEPT_SAT_EN for a saturating accumulator.
module percept_datapath #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 20
) (
  input  logic clk,
  input  logic nRst,
  input  logic in,
  input  logic shift,
  input  logic shift_res,
  input  logic mul,
  input  logic acc,
  output logic res_out,
  output logic busy,
  output logic prod_valid,
  output logic sat
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, SIGN} state_t;

  state_t             state_reg, state_next;
  logic [PW-1:0]      chain_reg, chain_next;
  logic [PW-1:0]      mx_reg, mx_next;
  logic [WIDTH-1:0]   mw_reg, mw_next;
  logic [PW-1:0]      pp_reg, pp_next;
  logic [PW-1:0]      prod_reg, prod_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               sign_reg, sign_next;
  logic               prod_valid_reg, prod_valid_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [ACC_W-1:0]   res_reg, res_next;
  logic               sat_reg, sat_next;

  logic [WIDTH-1:0]   x_op, w_op, x_mag, w_mag;

  assign x_op  = chain_reg[PW-1:WIDTH];
  assign w_op  = chain_reg[WIDTH-1:0];
  // -2^(W-1) negates to itself, which is the correct unsigned magnitude
  assign x_mag = x_op[WIDTH-1] ? -x_op : x_op;
  assign w_mag = w_op[WIDTH-1] ? -w_op : w_op;

`ifdef PERCEPT_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [ACC_W:0] acc_sum;
  assign acc_sum = {acc_reg[ACC_W-1], acc_reg}
                 + {{(ACC_W+1-PW){prod_reg[PW-1]}}, prod_reg};
`else
  logic [ACC_W-1:0] acc_sum;
  assign acc_sum = acc_reg + {{(ACC_W-PW){prod_reg[PW-1]}}, prod_reg};
`endif

  assign busy       = (state_reg != IDLE);
  assign prod_valid = prod_valid_reg;
  assign res_out    = res_reg[ACC_W-1];
  assign sat        = sat_reg;

  always_comb begin
    state_next      = state_reg;
    chain_next      = chain_reg;
    mx_next         = mx_reg;
    mw_next         = mw_reg;
    pp_next         = pp_reg;
    prod_next       = prod_reg;
    cnt_next        = cnt_reg;
    sign_next       = sign_reg;
    prod_valid_next = 1'b0;
    acc_next        = acc_reg;
    sat_next        = sat_reg;

    if (shift && !busy)
      chain_next = {chain_reg[PW-2:0], in};

    res_next = shift_res ? {res_reg[ACC_W-2:0], 1'b0} : acc_reg;

    case (state_reg)
      IDLE: begin
        if (mul && acc) begin
          acc_next = '0;
          sat_next = 1'b0;
        end else if (mul) begin
          // operands come from the pre-shift chain value
          mx_next    = {{WIDTH{1'b0}}, x_mag};
          mw_next    = w_mag;
          sign_next  = x_op[WIDTH-1] ^ w_op[WIDTH-1];
          pp_next    = '0;
          cnt_next   = CNT_W'(WIDTH);
          state_next = MUL;
        end else if (acc) begin
`ifdef PERCEPT_SAT_EN
          if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
            acc_next = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
            sat_next = 1'b1;
          end else begin
            acc_next = acc_sum[ACC_W-1:0];
          end
`else
          acc_next = acc_sum;
`endif
        end
      end
      MUL: begin
        if (mw_reg[0])
          pp_next = pp_reg + mx_reg;
        mx_next  = {mx_reg[PW-2:0], 1'b0};
        mw_next  = {1'b0, mw_reg[WIDTH-1:1]};
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1))
          state_next = SIGN;
      end
      SIGN: begin
        prod_next       = sign_reg ? -pp_reg : pp_reg;
        prod_valid_next = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg      <= IDLE;
      chain_reg      <= '0;
      mx_reg         <= '0;
      mw_reg         <= '0;
      pp_reg         <= '0;
      prod_reg       <= '0;
      cnt_reg        <= '0;
      sign_reg       <= 1'b0;
      prod_valid_reg <= 1'b0;
      acc_reg        <= '0;
      res_reg        <= '0;
      sat_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      chain_reg      <= chain_next;
      mx_reg         <= mx_next;
      mw_reg         <= mw_next;
      pp_reg         <= pp_next;
      prod_reg       <= prod_next;
      cnt_reg        <= cnt_next;
      sign_reg       <= sign_next;
      prod_valid_reg <= prod_valid_next;
      acc_reg        <= acc_next;
      res_reg        <= res_next;
      sat_reg        <= sat_next;
    end
  end

endmodule

// File: tb/tb_percept_datapath.sv
// Scoreboard bench for percept_datapath: stimulus pushes expected products/readouts,
// a negedge monitor pops and compares on prod_valid and on completed serial readouts.
module tb_percept_datapath;
  localparam int W  = 8;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic in_bit = 1'b0;
  logic shift = 1'b0;
  logic shift_res = 1'b0;
  logic mul = 1'b0;
  logic acc = 1'b0;
  wire  res_out, busy, prod_valid, sat;

  int checks = 0;
  int failures = 0;

  logic [2*W-1:0] prod_q[$];
  logic [AW-1:0]  res_q[$];

  percept_datapath #(.WIDTH(W), .ACC_W(AW)) dut (
    .clk(clk), .nRst(nRst), .in(in_bit), .shift(shift), .shift_res(shift_res),
    .mul(mul), .acc(acc), .res_out(res_out), .busy(busy),
    .prod_valid(prod_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s 0x%0h", name, act);
    end
  endtask

  // Monitor: counts busy cycles, checks products and serial readouts
  initial begin
    int busy_cnt;
    int rn;
    logic [AW-1:0] rbits;
    logic [2*W-1:0] pexp;
    logic [AW-1:0] rexp;
    busy_cnt = 0;
    rn = 0;
    rbits = '0;
    forever begin
      @(negedge clk);
      if (!nRst) begin
        busy_cnt = 0;
        rn = 0;
      end else begin
        if (busy) busy_cnt++;
        if (prod_valid) begin
          if (prod_q.size() == 0) begin
            check("unexpected_prod_valid", {31'd0, prod_valid}, 32'd0);
          end else begin
            pexp = prod_q.pop_front();
            check("product", {16'd0, dut.prod_reg}, {16'd0, pexp});
            check("busy_cycles", busy_cnt, W + 1);
          end
          busy_cnt = 0;
        end
        if (shift_res) begin
          rbits = {rbits[AW-2:0], res_out};
          rn++;
          if (rn == AW) begin
            rn = 0;
            if (res_q.size() == 0) begin
              check("unexpected_readout", {31'd0, shift_res}, 32'd0);
            end else begin
              rexp = res_q.pop_front();
              check("readout", {12'd0, rbits}, {12'd0, rexp});
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      shift = 1'b1;
      in_bit = b[i];
      tick();
    end
    shift = 1'b0;
    in_bit = 1'b0;
  endtask

  // Returns in the prod_valid cycle so a following strobe lands on that edge
  task automatic do_mul(input logic [15:0] exp, input logic noise);
    bit seen;
    seen = 1'b0;
    prod_q.push_back(exp);
    mul = 1'b1;
    tick();
    mul = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      shift = noise;
      in_bit = noise;
      tick();
      seen = prod_valid;
    end
    shift = 1'b0;
    in_bit = 1'b0;
    if (!seen) check("prod_valid_timeout", {31'd0, prod_valid}, 32'd1);
  endtask

  task automatic do_acc();
    acc = 1'b1;
    tick();
    acc = 1'b0;
  endtask

  task automatic do_clear();
    mul = 1'b1;
    acc = 1'b1;
    tick();
    mul = 1'b0;
    acc = 1'b0;
  endtask

  task automatic readout(input logic [AW-1:0] exp);
    shift_res = 1'b0;
    tick();
    tick();
    res_q.push_back(exp);
    shift_res = 1'b1;
    repeat (AW) tick();
    shift_res = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] sat_acc_exp;
    logic          sat_exp;
`ifdef PERCEPT_SAT_EN
    sat_acc_exp = 20'h7FFFF;
    sat_exp = 1'b1;
`else
    sat_acc_exp = 20'h80000;
    sat_exp = 1'b0;
`endif

    repeat (3) tick();
    nRst = 1'b1;
    tick();
    check("rst_res_out", {31'd0, res_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_prod_valid", {31'd0, prod_valid}, 32'd0);
    check("rst_sat", {31'd0, sat}, 32'd0);

    // 3 x 5
    shift_byte(8'h03);
    shift_byte(8'h05);
    do_mul(16'h000F, 1'b0);

    // -4 x 7, with shift noise during busy, repeated without reloading
    shift_byte(8'hFC);
    shift_byte(8'h07);
    do_mul(16'hFFE4, 1'b1);
    do_mul(16'hFFE4, 1'b1);
    do_clear();
    do_acc();
    readout(20'hFFFE4);
    check("sat_after_neg", {31'd0, sat}, 32'd0);

    // two 3 x 5 accumulations, acc issued on the prod_valid edge
    do_clear();
    shift_byte(8'h03);
    shift_byte(8'h05);
    do_mul(16'h000F, 1'b0);
    do_acc();
    do_mul(16'h000F, 1'b0);
    do_acc();
    readout(20'h0001E);

    // -128 x -128 accumulated 32 times hits the positive boundary
    shift_byte(8'h80);
    shift_byte(8'h80);
    do_mul(16'h4000, 1'b0);
    do_clear();
    acc = 1'b1;
    repeat (32) tick();
    acc = 1'b0;
    check("sat_boundary", {31'd0, sat}, {31'd0, sat_exp});
    readout(sat_acc_exp);
    do_clear();
    check("sat_cleared", {31'd0, sat}, 32'd0);
    readout(20'h00000);

    // reset mid-multiply
    do_acc();
    shift_byte(8'h03);
    shift_byte(8'h05);
    prod_q.push_back(16'h000F);
    mul = 1'b1;
    tick();
    mul = 1'b0;
    repeat (4) tick();
    nRst = 1'b0;
    prod_q.delete();
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_prod_reg", {16'd0, dut.prod_reg}, 32'd0);
    check("abort_prod_valid", {31'd0, prod_valid}, 32'd0);
    repeat (3) tick();
    nRst = 1'b1;
    repeat (12) tick();
    readout(20'h00000);

    shift_byte(8'h03);
    shift_byte(8'h05);
    do_mul(16'h000F, 1'b0);
    do_acc();
    readout(20'h0000F);

    repeat (4) tick();
    check("prod_q_drained", prod_q.size(), 32'd0);
    check("res_q_drained", res_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
